mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the CPU's single-port unified RAM between two requesters: m0 = CPU
//  core (fetch and load/store) and m1 = external master (boot loader / DMA).
//  Runs one transaction at a time with a req/ack handshake and a fixed-latency
//  RAM. Priority goes to m0, with a starvation limit that guarantees m1 progress.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  data width
//  RAM_LAT   1   cycles from address presented to ram_rdata valid (>=1)
//  MAX_HOLD  8   consecutive m0 grants allowed while m1_req pending (>=1)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       asynchronous, active-low reset
//  m0_req     in   1       m0 request; hold with fields stable until m0_ack
//  m0_we      in   1       m0 write (1) / read (0)
//  m0_addr    in   ADDR_W  m0 address
//  m0_wdata   in   DATA_W  m0 write data
//  m0_ack     out  1       one-cycle completion pulse to m0
//  m0_rdata   out  DATA_W  read data, valid while m0_ack=1
//  m1_req/m1_we/m1_addr/m1_wdata/m1_ack/m1_rdata: same as m0, for m1
//  ram_we     out  1       RAM write enable
//  ram_addr   out  ADDR_W  RAM address
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data
//  owner      out  1       current/last granted master (0=m0, 1=m1)
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, all acks 0, ram_we 0, ram_addr 0,
//   ram_wdata 0, m0/m1_rdata 0, owner 0, lat_cnt 0, starve_cnt 0.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE. All outputs are registered.
//  IDLE: if any req is high, pick a winner, latch its we/addr/wdata into
//   ram_*, set owner, and go to ACCESS. ram_we=1 only if the winner's we=1.
//  Arbitration:
//   - m1 wins if m1_req && (!m0_req || starve_cnt==MAX_HOLD); else m0 wins.
//   - starve_cnt: +1 (saturating at MAX_HOLD) on each m0 grant while m1_req=1;
//     cleared on each m1 grant; unchanged otherwise.
//  ACCESS: lasts exactly RAM_LAT cycles (lat_cnt counts 0..RAM_LAT-1).
//   - ram_we is high for the first ACCESS cycle only (one write per transaction).
//   - ram_addr/ram_wdata are held stable for the whole ACCESS phase.
//   - On the last cycle, ram_rdata is captured into owner's rdata; go to DONE.
//  DONE: owner's ack=1 for exactly one cycle, rdata valid (writes: rdata is
//   the captured ram_rdata, don't-care). Next state IDLE; req is not sampled
//   in DONE, so a requester deasserting in the ack cycle is never re-granted.
//  Latency: req seen in IDLE at edge t -> ack high in cycle t+RAM_LAT+1.
//   Back-to-back throughput: one transaction per RAM_LAT+2 cycles.
//  Non-owner: ack held 0, its rdata unchanged.
//  ram_addr/ram_wdata hold last values in IDLE/DONE; ram_we=0 outside ACCESS.
//  Boundaries:
//   - req dropped mid-transaction: transaction still completes and acks.
//   - Both reqs with starve_cnt==MAX_HOLD: m1 wins, starve_cnt -> 0.
//   - Reset mid-ACCESS: ram_we falls immediately (async), no ack issued.
//   - lat_cnt wraps to 0 on ACCESS exit; never exceeds RAM_LAT-1.
// TESTING
//  1 m0 read addr 0x40, RAM_LAT=1, RAM holds 0xDEADBEEF there -> m0_ack at
//    t+2 with m0_rdata=0xDEADBEEF; ram_we never asserted.
//  2 m1 write addr 0x100, data 0x12345678 -> ram_we high exactly 1 cycle;
//    m1_ack at t+2; read-back via m0 returns 0x12345678.
//  3 m0_req and m1_req held continuously, MAX_HOLD=8 -> grant order
//    m0 x8, then m1, then m0 x8 ...; no two acks ever in the same cycle.
//  4 RAM_LAT=3, m0 read -> ram_addr stable 3 cycles, m0_ack at t+4.
//  5 reset pulled low during ACCESS of a write -> ram_we 0 same cycle, all
//    outputs at reset values, no ack; after release, a new m0 read acks normally.
//  6 m0 drops req the cycle after grant -> m0_ack still pulses once; FSM
//    then returns to IDLE with no regrant.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single-port, fixed-latency RAM. m0 has priority;
// the starvation counter guarantees m1 a grant after MAX_HOLD m0 grants.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RAM_LAT  = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              owner
);

  localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]       state;
  logic [LAT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] starve_cnt;
  logic             m1_wins;
  logic             lat_last;
  logic             starve_full;

  always_comb begin
    starve_full = (starve_cnt == CNT_W'(MAX_HOLD));
    m1_wins     = m1_req && (!m0_req || starve_full);
    lat_last    = (lat_cnt == LAT_W'(RAM_LAT - 1));
  end

  // Acks and ram_we default low each cycle so they can only ever pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      owner      <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state   <= ACCESS;
            lat_cnt <= '0;
            owner   <= m1_wins;
            if (m1_wins) begin
              ram_we     <= m1_we;
              ram_addr   <= m1_addr;
              ram_wdata  <= m1_wdata;
              starve_cnt <= '0;
            end else begin
              ram_we    <= m0_we;
              ram_addr  <= m0_addr;
              ram_wdata <= m0_wdata;
              if (m1_req && !starve_full)
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end
        end
        ACCESS: begin
          if (lat_last) begin
            lat_cnt <= '0;
            state   <= DONE;
            if (owner) begin
              m1_rdata <= ram_rdata;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= ram_rdata;
              m0_ack   <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        // Requests are deliberately ignored here so a master that drops req
        // in its ack cycle is not granted again.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RAM_LAT=1 backed by
// a behavioural RAM, and one with RAM_LAT=3 backed by an address-derived pattern.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  int          checks;
  int          errors;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack, ram_we, owner;
  logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;

  logic        m0_req3, m0_we3, m1_req3, m1_we3;
  logic [31:0] m0_addr3, m0_wdata3, m1_addr3, m1_wdata3;
  logic        m0_ack3, m1_ack3, ram_we3, owner3;
  logic [31:0] m0_rdata3, m1_rdata3, ram_addr3, ram_wdata3, ram_rdata3;

  logic [31:0] mem [0:1023];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3), .MAX_HOLD(8)) dut3 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req3), .m0_we(m0_we3), .m0_addr(m0_addr3), .m0_wdata(m0_wdata3),
    .m0_ack(m0_ack3), .m0_rdata(m0_rdata3),
    .m1_req(m1_req3), .m1_we(m1_we3), .m1_addr(m1_addr3), .m1_wdata(m1_wdata3),
    .m1_ack(m1_ack3), .m1_rdata(m1_rdata3),
    .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
    .ram_rdata(ram_rdata3), .owner(owner3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata  = mem[ram_addr[11:2]];
  assign ram_rdata3 = {16'hC0DE, ram_addr3[15:0]};

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[11:2]] <= ram_wdata;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({m0_ack, m1_ack, ram_we, owner} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {m0_ack, m1_ack, ram_we, owner});
    end
    checks++;
    if ({ram_addr, ram_wdata, m0_rdata, m1_rdata} !== 128'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: addr=%h wdata=%h r0=%h r1=%h expected all 0",
               ram_addr, ram_wdata, m0_rdata, m1_rdata);
    end
    reset = 1'b1;
  endtask

  task test_m0_read;
    int lat, we_cycles;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40; m0_wdata = 32'h0;
    lat = 0; we_cycles = 0;
    while (!m0_ack && lat < 20) begin
      @(negedge clk); lat++;
      if (ram_we) we_cycles++;
    end
    m0_req = 1'b0;
    checks++;
    if (lat != 2) begin
      errors++;
      $display("[TB] FAIL m0_read_latency: got %0d expected 2", lat);
    end
    checks++;
    if (m0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL m0_read_data: got %h expected deadbeef", m0_rdata);
    end
    checks++;
    if (we_cycles != 0) begin
      errors++;
      $display("[TB] FAIL m0_read_no_we: got %0d we cycles expected 0", we_cycles);
    end
  endtask

  task test_m1_write;
    int lat, we_cycles;
    logic [31:0] m1_saved;
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h100; m1_wdata = 32'h12345678;
    lat = 0; we_cycles = 0;
    while (!m1_ack && lat < 20) begin
      @(negedge clk); lat++;
      if (ram_we) we_cycles++;
    end
    m1_req = 1'b0; m1_we = 1'b0;
    checks++;
    if (lat != 2) begin
      errors++;
      $display("[TB] FAIL m1_write_latency: got %0d expected 2", lat);
    end
    checks++;
    if (we_cycles != 1) begin
      errors++;
      $display("[TB] FAIL m1_write_we_pulse: got %0d cycles expected 1", we_cycles);
    end
    checks++;
    if (owner !== 1'b1 || m0_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL m1_write_owner: owner=%b m0_ack=%b expected owner=1 m0_ack=0", owner, m0_ack);
    end
    m1_saved = m1_rdata;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    lat = 0;
    while (!m0_ack && lat < 20) begin
      @(negedge clk); lat++;
    end
    m0_req = 1'b0;
    checks++;
    if (lat != 2 || m0_rdata !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL readback: latency %0d data %h expected 2 / 12345678", lat, m0_rdata);
    end
    checks++;
    if (m1_rdata !== m1_saved || owner !== 1'b0) begin
      errors++;
      $display("[TB] FAIL non_owner_hold: m1_rdata=%h owner=%b expected %h / 0", m1_rdata, owner, m1_saved);
    end
  endtask

  task test_starvation;
    int n_ack, cyc;
    logic exp_m1;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h100;
    n_ack = 0; cyc = 0;
    while (n_ack < 18 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (m0_ack || m1_ack) begin
        exp_m1 = (n_ack == 8) || (n_ack == 17);
        checks++;
        if ({m0_ack, m1_ack} !== {!exp_m1, exp_m1}) begin
          errors++;
          $display("[TB] FAIL grant_order: grant %0d acks m0=%b m1=%b expected m0=%b m1=%b",
                   n_ack, m0_ack, m1_ack, !exp_m1, exp_m1);
        end
        checks++;
        if (exp_m1 ? (m1_rdata !== 32'h12345678) : (m0_rdata !== 32'hDEADBEEF)) begin
          errors++;
          $display("[TB] FAIL grant_data: grant %0d m0_rdata=%h m1_rdata=%h", n_ack, m0_rdata, m1_rdata);
        end
        n_ack++;
        if (n_ack == 18) begin
          m0_req = 1'b0; m1_req = 1'b0;
        end
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    checks++;
    if (n_ack != 18) begin
      errors++;
      $display("[TB] FAIL starvation_timeout: got %0d acks expected 18", n_ack);
    end
  endtask

  task test_long_latency;
    int lat, addr_bad, we_cycles;
    @(negedge clk);
    m0_req3 = 1'b1; m0_we3 = 1'b0; m0_addr3 = 32'h80; m0_wdata3 = 32'h55;
    lat = 0; addr_bad = 0; we_cycles = 0;
    while (!m0_ack3 && lat < 20) begin
      @(negedge clk); lat++;
      if (ram_we3) we_cycles++;
      if (lat <= 3 && ram_addr3 !== 32'h80) addr_bad++;
    end
    m0_req3 = 1'b0;
    checks++;
    if (lat != 4) begin
      errors++;
      $display("[TB] FAIL lat3_latency: got %0d expected 4", lat);
    end
    checks++;
    if (addr_bad != 0 || ram_wdata3 !== 32'h55) begin
      errors++;
      $display("[TB] FAIL lat3_addr_stable: %0d unstable cycles, wdata %h expected 0 / 00000055", addr_bad, ram_wdata3);
    end
    checks++;
    if (m0_rdata3 !== 32'hC0DE0080) begin
      errors++;
      $display("[TB] FAIL lat3_data: got %h expected c0de0080", m0_rdata3);
    end
    checks++;
    if (we_cycles != 0 || m1_ack3 !== 1'b0 || owner3 !== 1'b0 || m1_rdata3 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL lat3_side: we=%0d m1_ack=%b owner=%b m1_rdata=%h expected 0/0/0/0",
               we_cycles, m1_ack3, owner3, m1_rdata3);
    end
  endtask

  task test_reset_mid_access;
    int acks, lat;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'hBAD0BAD0;
    @(posedge clk);
    #2;
    checks++;
    if (ram_we !== 1'b1) begin
      errors++;
      $display("[TB] FAIL access_we_before_reset: got %b expected 1", ram_we);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({ram_we, m0_ack, m1_ack, owner} !== 4'b0000 || ram_addr !== 32'h0 || ram_wdata !== 32'h0
        || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: we=%b acks=%b%b owner=%b addr=%h wdata=%h expected all 0",
               ram_we, m0_ack, m1_ack, owner, ram_addr, ram_wdata);
    end
    m0_req = 1'b0; m0_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (m0_ack || m1_ack) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("[TB] FAIL reset_no_ack: got %0d acks expected 0", acks);
    end
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 32'h40;
    lat = 0;
    while (!m0_ack && lat < 20) begin
      @(negedge clk); lat++;
    end
    m0_req = 1'b0;
    checks++;
    if (lat != 2 || m0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL post_reset_read: latency %0d data %h expected 2 / deadbeef", lat, m0_rdata);
    end
  endtask

  task test_req_drop;
    int acks, cyc;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    @(negedge clk);
    m0_req = 1'b0;
    acks = 0; cyc = 0;
    repeat (10) begin
      @(negedge clk); cyc++;
      if (m0_ack) begin
        acks++;
        checks++;
        if (cyc != 1 || m0_rdata !== 32'h12345678) begin
          errors++;
          $display("[TB] FAIL drop_ack: at cycle %0d data %h expected cycle 1 / 12345678", cyc, m0_rdata);
        end
      end
    end
    checks++;
    if (acks != 1 || m1_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_no_regrant: got %0d acks expected 1", acks);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    m0_req3 = 0; m0_we3 = 0; m0_addr3 = 0; m0_wdata3 = 0;
    m1_req3 = 0; m1_we3 = 0; m1_addr3 = 0; m1_wdata3 = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem[16] = 32'hDEADBEEF;
    test_reset();
    test_m0_read();
    test_m1_write();
    test_starvation();
    test_long_latency();
    test_reset_mid_access();
    test_req_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
